// File: rtl/memory_pkg.sv
// Shared types and constants for sync_memory and its read pipeline.
package memory_pkg;

    typedef enum logic {
        MEM_CLEAR = 1'b0,
        MEM_READY = 1'b1
    } mem_state_t;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 16;

    function automatic bit read_latency_legal(input int latency);
        return (latency == 1) || (latency == 2);
    endfunction

endpackage

// File: rtl/memory_read_pipe.sv
// LATENCY-deep valid/data shift stage for read responses; flush drops in-flight reads.
module memory_read_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic                  valid_q [LATENCY];
    logic [DATA_WIDTH-1:0] data_q  [LATENCY];

    // Data only advances with its valid bit, so the output holds the last response.
    always_ff @(posedge clk) begin
        if (flush) begin
            valid_q[0] <= 1'b0;
            data_q[0]  <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
        end
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        always_ff @(posedge clk) begin
            if (flush) begin
                valid_q[g] <= 1'b0;
                data_q[g]  <= '0;
            end else begin
                valid_q[g] <= valid_q[g-1];
                if (valid_q[g-1]) begin
                    data_q[g] <= data_q[g-1];
                end
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/sync_memory.sv
// Single-port word memory with byte masks and valid/ready requests.
// MEMORY_CLEAR_ON_RESET_EN builds the clear engine:  MEM_CLEAR | zeroing words 0..DEPTH-1, busy ; MEM_READY | serving requests
module sync_memory
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_read_write,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    busy
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("sync_memory: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("sync_memory: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_index;

`ifdef MEMORY_CLEAR_ON_RESET_EN
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CLR_STEP = (ADDR_WIDTH + 1)'(1);

    mem_state_t          state_q;
    mem_state_t          state_d;
    logic [ADDR_WIDTH:0] clr_addr_q;
    logic [ADDR_WIDTH:0] clr_addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= MEM_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we     = 1'b0;
        busy       = 1'b0;
        case (state_q)
            MEM_CLEAR: begin
                busy       = 1'b1;
                clr_we     = 1'b1;
                clr_addr_d = clr_addr_q + CLR_STEP;
                if (clr_addr_q == CLR_LAST) begin
                    state_d = MEM_READY;
                end
            end
            MEM_READY: begin
                state_d = MEM_READY;
            end
            default: begin
                state_d    = MEM_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    assign clr_index = clr_addr_q[ADDR_WIDTH-1:0];
    assign req_ready = !busy;
`else
    logic ready_q;

    // Ready is registered so it stays low for the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign busy      = 1'b0;
    assign clr_we    = 1'b0;
    assign clr_index = '0;
    assign req_ready = ready_q;
`endif

    assign accept    = req_valid && req_ready && !reset;
    assign wr_accept = accept && !req_read_write;
    assign rd_accept = accept && req_read_write;

    always_ff @(posedge clk) begin
        if (clr_we && !reset) begin
            mem[clr_index] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (req_wmask[b]) begin
                    mem[req_address][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[req_address];

    memory_read_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_read_pipe (
        .clk       (clk),
        .flush     (reset),
        .in_valid  (rd_accept),
        .in_data   (rd_word),
        .out_valid (rsp_valid),
        .out_data  (rsp_rdata)
    );

endmodule
